// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with architectural HI/LO
// registers. Multiplies by shift-add and divides by restoring shift-subtract,
// one bit per clock, on operand magnitudes. A final FIX cycle applies the
// sign correction and commits the result to HI/LO.
module mul_div_unit #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic [2:0]            op_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic                  flush_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  div_by_zero_o,
   output logic [DATA_WIDTH-1:0] hi_o,
   output logic [DATA_WIDTH-1:0] lo_o
);

   localparam int W     = DATA_WIDTH;
   localparam int CNT_W = $clog2(W + 1);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(W - 1);

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [W-1:0]       hi_q, hi_d;
   logic [W-1:0]       lo_q, lo_d;
   logic [2*W-1:0]     acc_q, acc_d;
   logic [2*W-1:0]     mcand_q, mcand_d;
   logic [W-1:0]       mplier_q, mplier_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               negRes_q, negRes_d;
   logic               negRem_q, negRem_d;
   logic               isDiv_q, isDiv_d;
   logic               dbzPend_q, dbzPend_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               dbz_q, dbz_d;

   logic               isSigned;
   logic               aNeg, bNeg;
   logic [W-1:0]       aMag, bMag;
   logic [2*W-1:0]     mulSum;
   logic [W:0]         divRemShift;
   logic [W:0]         divDiff;
   logic [2*W-1:0]     product;
   logic [W-1:0]       quot, rem;

   // Operand magnitudes and sign flags for the op being issued; bit 0 of the
   // opcode distinguishes the unsigned variants. The most-negative value maps
   // to itself, which is its correct unsigned magnitude.
   always_comb begin
      isSigned = ~op_i[0];
      aNeg     = isSigned & a_i[W-1];
      bNeg     = isSigned & b_i[W-1];
      aMag     = aNeg ? -a_i : a_i;
      bMag     = bNeg ? -b_i : b_i;
   end

   // Datapath for one iteration and for the final sign correction.
   always_comb begin
      mulSum      = acc_q + (mplier_q[0] ? mcand_q : '0);
      divRemShift = acc_q[2*W-1:W-1];
      divDiff     = divRemShift - {1'b0, mcand_q[W-1:0]};
      product     = negRes_q ? -acc_q : acc_q;
      quot        = negRes_q ? -acc_q[W-1:0] : acc_q[W-1:0];
      rem         = negRem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
   end

   // Next-state logic: issue in IDLE, iterate in MUL/DIV, commit in FIX.
   // A flush drops any busy state straight back to IDLE and beats the commit.
   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      negRes_d  = negRes_q;
      negRem_d  = negRem_q;
      isDiv_d   = isDiv_q;
      dbzPend_d = dbzPend_q;
      done_d    = 1'b0;
      dbz_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i && !flush_i) begin
               unique case (op_i)
                  OP_MULT, OP_MULTU: begin
                     mcand_d   = {{W{1'b0}}, aMag};
                     mplier_d  = bMag;
                     acc_d     = '0;
                     cnt_d     = '0;
                     negRes_d  = aNeg ^ bNeg;
                     isDiv_d   = 1'b0;
                     dbzPend_d = 1'b0;
                     state_d   = MUL;
                  end
                  OP_DIV, OP_DIVU: begin
                     mcand_d   = {{W{1'b0}}, bMag};
                     acc_d     = {{W{1'b0}}, aMag};
                     cnt_d     = '0;
                     negRes_d  = aNeg ^ bNeg;
                     negRem_d  = aNeg;
                     isDiv_d   = 1'b1;
                     dbzPend_d = (b_i == '0);
                     state_d   = (b_i == '0) ? FIX : DIV;
                  end
                  OP_MTHI: hi_d = a_i;
                  OP_MTLO: lo_d = a_i;
                  default: ;
               endcase
            end
         end
         MUL: begin
            if (flush_i) begin
               state_d = IDLE;
            end else begin
               acc_d    = mulSum;
               mcand_d  = mcand_q << 1;
               mplier_d = mplier_q >> 1;
               cnt_d    = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_ITER) state_d = FIX;
            end
         end
         DIV: begin
            if (flush_i) begin
               state_d = IDLE;
            end else begin
               if (!divDiff[W]) acc_d = {divDiff[W-1:0], acc_q[W-2:0], 1'b1};
               else             acc_d = {divRemShift[W-1:0], acc_q[W-2:0], 1'b0};
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == LAST_ITER) state_d = FIX;
            end
         end
         FIX: begin
            state_d = IDLE;
            if (!flush_i) begin
               done_d = 1'b1;
               if (dbzPend_q) begin
                  dbz_d = 1'b1;
               end else if (isDiv_q) begin
                  lo_d = quot;
                  hi_d = rem;
               end else begin
                  hi_d = product[2*W-1:W];
                  lo_d = product[W-1:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   // State and datapath registers; reset clears everything mid-operation too.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         hi_q      <= '0;
         lo_q      <= '0;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         negRes_q  <= 1'b0;
         negRem_q  <= 1'b0;
         isDiv_q   <= 1'b0;
         dbzPend_q <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         negRes_q  <= negRes_d;
         negRem_q  <= negRem_d;
         isDiv_q   <= isDiv_d;
         dbzPend_q <= dbzPend_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dbz_q     <= dbz_d;
      end
   end

   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign div_by_zero_o = dbz_q;
   assign hi_o          = hi_q;
   assign lo_o          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed tests for mul_div_unit at DATA_WIDTH = 32.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mul_div_unit;

   localparam logic [2:0] OP_MULT  = 3'b000;
   localparam logic [2:0] OP_MULTU = 3'b001;
   localparam logic [2:0] OP_DIV   = 3'b010;
   localparam logic [2:0] OP_DIVU  = 3'b011;
   localparam logic [2:0] OP_MTHI  = 3'b100;
   localparam logic [2:0] OP_MTLO  = 3'b101;

   logic        clk = 1'b0;
   logic        reset;
   logic        startI;
   logic [2:0]  opI;
   logic [31:0] aI, bI;
   logic        flushI;
   logic        busyO, doneO, dbzO;
   logic [31:0] hiO, loO;

   int checkCount = 0;
   int passCount  = 0;

   mul_div_unit #(.DATA_WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start_i(startI), .op_i(opI),
      .a_i(aI), .b_i(bI), .flush_i(flushI), .busy_o(busyO),
      .done_o(doneO), .div_by_zero_o(dbzO), .hi_o(hiO), .lo_o(loO)
   );

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   // Issue an op from the current falling edge and wait until busy drops,
   // counting busy cycles; returns on the falling edge of the done cycle.
   task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int busyCycles);
      startI = 1'b1; opI = op; aI = a; bI = b;
      @(negedge clk);
      startI = 1'b0;
      busyCycles = 0;
      while (busyO && busyCycles < 100) begin
         busyCycles++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      checkCount++; if (hiO !== 32'h0) $display("[TB] FAIL reset_hi: got %h want 0", hiO); else passCount++;
      checkCount++; if (loO !== 32'h0) $display("[TB] FAIL reset_lo: got %h want 0", loO); else passCount++;
      checkCount++; if (busyO !== 1'b0) $display("[TB] FAIL reset_busy: got %b want 0", busyO); else passCount++;
      checkCount++; if (doneO !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", doneO); else passCount++;
      checkCount++; if (dbzO !== 1'b0) $display("[TB] FAIL reset_dbz: got %b want 0", dbzO); else passCount++;
   endtask

   task automatic test_mult;
      int bc;
      runOp(OP_MULT, 32'hFFFF_FFFD, 32'd5, bc);
      checkCount++; if (bc !== 33) $display("[TB] FAIL mult_busy_cycles: got %0d want 33", bc); else passCount++;
      checkCount++; if (doneO !== 1'b1) $display("[TB] FAIL mult_done: got %b want 1", doneO); else passCount++;
      checkCount++; if (dbzO !== 1'b0) $display("[TB] FAIL mult_dbz: got %b want 0", dbzO); else passCount++;
      checkCount++; if (hiO !== 32'hFFFF_FFFF) $display("[TB] FAIL mult_hi: got %h want ffffffff", hiO); else passCount++;
      checkCount++; if (loO !== 32'hFFFF_FFF1) $display("[TB] FAIL mult_lo: got %h want fffffff1", loO); else passCount++;
      @(negedge clk);
      checkCount++; if (doneO !== 1'b0) $display("[TB] FAIL mult_done_pulse: got %b want 0", doneO); else passCount++;
   endtask

   task automatic test_multu;
      int bc;
      runOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, bc);
      checkCount++; if (doneO !== 1'b1) $display("[TB] FAIL multu_done: got %b want 1", doneO); else passCount++;
      checkCount++; if (hiO !== 32'hFFFF_FFFE) $display("[TB] FAIL multu_hi: got %h want fffffffe", hiO); else passCount++;
      checkCount++; if (loO !== 32'h0000_0001) $display("[TB] FAIL multu_lo: got %h want 00000001", loO); else passCount++;
   endtask

   task automatic test_div;
      int bc;
      runOp(OP_DIV, 32'hFFFF_FFF9, 32'd2, bc);
      checkCount++; if (bc !== 33) $display("[TB] FAIL div_busy_cycles: got %0d want 33", bc); else passCount++;
      checkCount++; if (loO !== 32'hFFFF_FFFD) $display("[TB] FAIL div_neg_lo: got %h want fffffffd", loO); else passCount++;
      checkCount++; if (hiO !== 32'hFFFF_FFFF) $display("[TB] FAIL div_neg_hi: got %h want ffffffff", hiO); else passCount++;
      runOp(OP_DIVU, 32'd7, 32'd2, bc);
      checkCount++; if (loO !== 32'd3) $display("[TB] FAIL divu_lo: got %h want 3", loO); else passCount++;
      checkCount++; if (hiO !== 32'd1) $display("[TB] FAIL divu_hi: got %h want 1", hiO); else passCount++;
      runOp(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, bc);
      checkCount++; if (loO !== 32'h8000_0000) $display("[TB] FAIL div_minneg_lo: got %h want 80000000", loO); else passCount++;
      checkCount++; if (hiO !== 32'h0) $display("[TB] FAIL div_minneg_hi: got %h want 0", hiO); else passCount++;
   endtask

   task automatic test_mthi_mtlo;
      startI = 1'b1; opI = OP_MTHI; aI = 32'h1234; bI = 32'h0;
      @(negedge clk);
      startI = 1'b0;
      checkCount++; if (busyO !== 1'b0) $display("[TB] FAIL mthi_busy: got %b want 0", busyO); else passCount++;
      checkCount++; if (hiO !== 32'h1234) $display("[TB] FAIL mthi_hi: got %h want 1234", hiO); else passCount++;
      startI = 1'b1; opI = OP_MTLO; aI = 32'h5678;
      @(negedge clk);
      startI = 1'b0;
      checkCount++; if (loO !== 32'h5678) $display("[TB] FAIL mtlo_lo: got %h want 5678", loO); else passCount++;
      checkCount++; if (doneO !== 1'b0) $display("[TB] FAIL mtlo_done: got %b want 0", doneO); else passCount++;
      startI = 1'b1; opI = 3'b110; aI = 32'hDEAD;
      @(negedge clk);
      startI = 1'b0;
      checkCount++; if (hiO !== 32'h1234 || loO !== 32'h5678 || busyO !== 1'b0)
         $display("[TB] FAIL illegal_op: got hi=%h lo=%h busy=%b want 1234/5678/0", hiO, loO, busyO); else passCount++;
      startI = 1'b1; flushI = 1'b1; opI = OP_MTHI; aI = 32'hBEEF;
      @(negedge clk);
      startI = 1'b0; flushI = 1'b0;
      checkCount++; if (hiO !== 32'h1234) $display("[TB] FAIL mthi_flushed: got %h want 1234", hiO); else passCount++;
   endtask

   task automatic test_div_by_zero;
      int bc;
      runOp(OP_DIVU, 32'd9, 32'd0, bc);
      checkCount++; if (bc !== 1) $display("[TB] FAIL dbz_busy_cycles: got %0d want 1", bc); else passCount++;
      checkCount++; if (doneO !== 1'b1) $display("[TB] FAIL dbz_done: got %b want 1", doneO); else passCount++;
      checkCount++; if (dbzO !== 1'b1) $display("[TB] FAIL dbz_flag: got %b want 1", dbzO); else passCount++;
      checkCount++; if (hiO !== 32'h1234) $display("[TB] FAIL dbz_hi: got %h want 1234", hiO); else passCount++;
      checkCount++; if (loO !== 32'h5678) $display("[TB] FAIL dbz_lo: got %h want 5678", loO); else passCount++;
      @(negedge clk);
      checkCount++; if (dbzO !== 1'b0) $display("[TB] FAIL dbz_pulse: got %b want 0", dbzO); else passCount++;
   endtask

   task automatic test_flush;
      logic doneSeen;
      startI = 1'b1; opI = OP_MULT; aI = 32'd6; bI = 32'd7;
      @(negedge clk);
      startI = 1'b0;
      repeat (9) @(negedge clk);
      flushI = 1'b1;
      @(negedge clk);
      flushI = 1'b0;
      checkCount++; if (busyO !== 1'b0) $display("[TB] FAIL flush_busy: got %b want 0", busyO); else passCount++;
      doneSeen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (doneO) doneSeen = 1'b1;
         @(negedge clk);
      end
      checkCount++; if (doneSeen !== 1'b0) $display("[TB] FAIL flush_no_done: got %b want 0", doneSeen); else passCount++;
      checkCount++; if (hiO !== 32'h1234 || loO !== 32'h5678)
         $display("[TB] FAIL flush_hold: got hi=%h lo=%h want 1234/5678", hiO, loO); else passCount++;
   endtask

   task automatic test_ignored_start;
      int bc;
      startI = 1'b1; opI = OP_MULTU; aI = 32'd6; bI = 32'd7;
      @(negedge clk);
      startI = 1'b0;
      bc = 0;
      while (busyO && bc < 100) begin
         bc++;
         if (bc == 5) begin
            startI = 1'b1; opI = OP_DIVU; aI = 32'd100; bI = 32'd3;
         end else begin
            startI = 1'b0;
         end
         @(negedge clk);
      end
      startI = 1'b0;
      checkCount++; if (bc !== 33) $display("[TB] FAIL ignstart_busy_cycles: got %0d want 33", bc); else passCount++;
      checkCount++; if (loO !== 32'd42 || hiO !== 32'd0)
         $display("[TB] FAIL ignstart_result: got hi=%h lo=%h want 0/2a", hiO, loO); else passCount++;
      @(negedge clk);
      checkCount++; if (busyO !== 1'b0) $display("[TB] FAIL ignstart_no_queue: got %b want 0", busyO); else passCount++;
   endtask

   task automatic test_flush_commit;
      startI = 1'b1; opI = OP_MULTU; aI = 32'd3; bI = 32'd3;
      @(negedge clk);
      startI = 1'b0;
      repeat (32) @(negedge clk);
      flushI = 1'b1;
      @(negedge clk);
      flushI = 1'b0;
      checkCount++; if (busyO !== 1'b0 || doneO !== 1'b0)
         $display("[TB] FAIL flushfix_state: got busy=%b done=%b want 0/0", busyO, doneO); else passCount++;
      @(negedge clk);
      checkCount++; if (hiO !== 32'd0 || loO !== 32'd42)
         $display("[TB] FAIL flushfix_hold: got hi=%h lo=%h want 0/2a", hiO, loO); else passCount++;
   endtask

   task automatic test_back_to_back;
      int bc;
      runOp(OP_MULTU, 32'd5, 32'd5, bc);
      checkCount++; if (loO !== 32'd25 || doneO !== 1'b1)
         $display("[TB] FAIL b2b_first: got lo=%h done=%b want 19/1", loO, doneO); else passCount++;
      runOp(OP_DIVU, 32'd100, 32'd7, bc);
      checkCount++; if (bc !== 33) $display("[TB] FAIL b2b_busy_cycles: got %0d want 33", bc); else passCount++;
      checkCount++; if (loO !== 32'd14 || hiO !== 32'd2)
         $display("[TB] FAIL b2b_second: got hi=%h lo=%h want 2/e", hiO, loO); else passCount++;
   endtask

   task automatic test_reset_mid;
      int bc;
      startI = 1'b1; opI = OP_DIV; aI = 32'd100; bI = 32'd7;
      @(negedge clk);
      startI = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checkCount++; if (hiO !== 32'd0 || loO !== 32'd0)
         $display("[TB] FAIL rstmid_hilo: got hi=%h lo=%h want 0/0", hiO, loO); else passCount++;
      checkCount++; if (busyO !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b want 0", busyO); else passCount++;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      runOp(OP_MULTU, 32'd6, 32'd7, bc);
      checkCount++; if (bc !== 33) $display("[TB] FAIL rstmid_busy_cycles: got %0d want 33", bc); else passCount++;
      checkCount++; if (loO !== 32'd42 || hiO !== 32'd0)
         $display("[TB] FAIL rstmid_result: got hi=%h lo=%h want 0/2a", hiO, loO); else passCount++;
   endtask

   // Test sequence: reset, then each scenario in turn, then the summary.
   initial begin
      reset = 1'b0; startI = 1'b0; opI = 3'b000; aI = '0; bI = '0; flushI = 1'b0;
      repeat (3) @(negedge clk);
      test_reset;
      reset = 1'b1;
      @(negedge clk);
      test_mult;
      test_multu;
      test_div;
      test_mthi_mtlo;
      test_div_by_zero;
      test_flush;
      test_ignored_start;
      test_flush_commit;
      test_back_to_back;
      test_reset_mid;
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
